// File: rtl/hazard_unit_pkg.sv
// Shared types for the hazard unit: forwarding selects, wait-FSM states
// and the forwarding priority function used by both ALU operands.
package hazard_unit_pkg;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,   // operand from the register file
      FWD_WB  = 2'b01,   // operand from ResultW
      FWD_MEM = 2'b10    // operand from ALUOutM
   } fwd_sel_e;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_WAIT = 1'b1
   } hu_state_e;

   localparam int WAIT_CNT_W = 8;

   // Memory stage wins over writeback because it holds the younger result.
   // Register $0 is hard-wired to zero and is never forwarded.
   function automatic fwd_sel_e fwd_select(input logic [4:0] rs,
                                           input logic [4:0] wr_m,
                                           input logic       rw_m,
                                           input logic [4:0] wr_w,
                                           input logic       rw_w);
      fwd_sel_e sel;
      sel = FWD_RF;
      if (rs != 5'd0 && rs == wr_m && rw_m)      sel = FWD_MEM;
      else if (rs != 5'd0 && rs == wr_w && rw_w) sel = FWD_WB;
      return sel;
   endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit bundle. The pipeline (master) supplies register
// fields and control bits; the hazard unit (slave) returns stalls/flushes,
// forwarding selects, the wait error and the performance counters.
interface hazard_unit_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       HU_RsD, HU_RtD, HU_RsE, HU_RtE;
   logic [4:0]       HU_WriteRegE, HU_WriteRegM, HU_WriteRegW;
   logic             HU_RegWriteE, HU_RegWriteM, HU_RegWriteW;
   logic             HU_MemToRegE, HU_MemToRegM, HU_MemWriteM;
   logic             HU_BranchD, HU_MemReadyM;

   logic             HU_StallF, HU_StallD, HU_StallE, HU_StallM;
   logic             HU_FlushE, HU_FlushW;
   logic             HU_ForwardAD, HU_ForwardBD;
   logic [1:0]       HU_ForwardAE, HU_ForwardBE;
   logic             HU_MemErr;
   logic [CNT_W-1:0] HU_StallCnt, HU_FlushCnt;

   modport master (
      output HU_RsD, HU_RtD, HU_RsE, HU_RtE,
             HU_WriteRegE, HU_WriteRegM, HU_WriteRegW,
             HU_RegWriteE, HU_RegWriteM, HU_RegWriteW,
             HU_MemToRegE, HU_MemToRegM, HU_MemWriteM,
             HU_BranchD, HU_MemReadyM,
      input  HU_StallF, HU_StallD, HU_StallE, HU_StallM,
             HU_FlushE, HU_FlushW, HU_ForwardAD, HU_ForwardBD,
             HU_ForwardAE, HU_ForwardBE, HU_MemErr,
             HU_StallCnt, HU_FlushCnt
   );

   modport slave (
      input  HU_RsD, HU_RtD, HU_RsE, HU_RtE,
             HU_WriteRegE, HU_WriteRegM, HU_WriteRegW,
             HU_RegWriteE, HU_RegWriteM, HU_RegWriteW,
             HU_MemToRegE, HU_MemToRegM, HU_MemWriteM,
             HU_BranchD, HU_MemReadyM,
      output HU_StallF, HU_StallD, HU_StallE, HU_StallM,
             HU_FlushE, HU_FlushW, HU_ForwardAD, HU_ForwardBD,
             HU_ForwardAE, HU_ForwardBE, HU_MemErr,
             HU_StallCnt, HU_FlushCnt
   );
endinterface

// File: rtl/hu_sat_counter.sv
// W-bit event counter that sticks at all-ones instead of wrapping.
module hu_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);
   localparam logic [W-1:0] ONE = W'(1);

   logic [W-1:0] cnt_q, cnt_d;

   // Next count: hold at all-ones once saturated.
   always_comb begin
      // NOTE: default first so every path assigns cnt_d and no latch is inferred.
      cnt_d = cnt_q;
      if (inc_i && cnt_q != '1) cnt_d = cnt_q + ONE;
   end

   // Count register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: non-blocking assignment for state so all flops update together.
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage MIPS pipeline: forwarding selects,
// load-use and branch stalls, data-memory wait FSM with timeout flag,
// and saturating stall/flush cycle counters.
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 15
) (
   input  logic          HU_CLK,
   input  logic          HU_RST,
   hazard_unit_if.slave  hu
);
   localparam logic [WAIT_CNT_W-1:0] TIMEOUT_C = WAIT_CNT_W'(TIMEOUT);

   hu_state_e              state_q, state_d;
   logic [WAIT_CNT_W-1:0]  wcnt_q, wcnt_d;
   logic                   memerr_q, memerr_d;
   logic                   lwstall, brstall, memwait;
   logic                   mem_hold, hazard;
   logic                   stall_f, flush_e;

   // Forwarding selects and raw hazard detection.
   always_comb begin
      hu.HU_ForwardAE = fwd_select(hu.HU_RsE, hu.HU_WriteRegM, hu.HU_RegWriteM,
                                   hu.HU_WriteRegW, hu.HU_RegWriteW);
      hu.HU_ForwardBE = fwd_select(hu.HU_RtE, hu.HU_WriteRegM, hu.HU_RegWriteM,
                                   hu.HU_WriteRegW, hu.HU_RegWriteW);
      hu.HU_ForwardAD = (hu.HU_RsD != 5'd0) && (hu.HU_RsD == hu.HU_WriteRegM) && hu.HU_RegWriteM;
      hu.HU_ForwardBD = (hu.HU_RtD != 5'd0) && (hu.HU_RtD == hu.HU_WriteRegM) && hu.HU_RegWriteM;
      lwstall = hu.HU_MemToRegE &&
                ((hu.HU_RtE == hu.HU_RsD) || (hu.HU_RtE == hu.HU_RtD));
      brstall = hu.HU_BranchD &&
                ((hu.HU_RegWriteE && ((hu.HU_WriteRegE == hu.HU_RsD) ||
                                      (hu.HU_WriteRegE == hu.HU_RtD))) ||
                 (hu.HU_MemToRegM && ((hu.HU_WriteRegM == hu.HU_RsD) ||
                                      (hu.HU_WriteRegM == hu.HU_RtD))));
      memwait = (hu.HU_MemToRegM || hu.HU_MemWriteM) && !hu.HU_MemReadyM;
   end

   // Wait FSM state, wait counter and sticky error register.
   always_ff @(posedge HU_CLK or posedge HU_RST) begin
      if (HU_RST) begin
         state_q  <= ST_RUN;
         wcnt_q   <= '0;
         memerr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wcnt_q   <= wcnt_d;
         memerr_q <= memerr_d;
      end
   end

   // Next-state: enter WAIT on a stalled access, leave when memory is ready.
   always_comb begin
      state_d  = state_q;
      wcnt_d   = wcnt_q;
      memerr_d = memerr_q;
      unique case (state_q)
         ST_RUN: begin
            if (memwait) begin
               state_d = ST_WAIT;
               wcnt_d  = WAIT_CNT_W'(1);
            end
         end
         ST_WAIT: begin
            if (hu.HU_MemReadyM) begin
               state_d = ST_RUN;
               wcnt_d  = '0;
            end else if (wcnt_q != '1) begin
               wcnt_d = wcnt_q + WAIT_CNT_W'(1);
            end
         end
         default: state_d = ST_RUN;
      endcase
      if (wcnt_d == TIMEOUT_C) memerr_d = 1'b1;
   end

   // Outputs: a memory hold freezes F..M and bubbles W; otherwise hazards
   // stall F/D and clear E. Reset forces every stall and flush low.
   always_comb begin
      mem_hold = 1'b0;
      if (!HU_RST) begin
         if (state_q == ST_WAIT) mem_hold = !hu.HU_MemReadyM;
         else                    mem_hold = memwait;
      end
      hazard  = (lwstall || brstall) && !HU_RST;
      stall_f = mem_hold || hazard;
      flush_e = !mem_hold && hazard;
      hu.HU_StallF = stall_f;
      hu.HU_StallD = stall_f;
      hu.HU_FlushE = flush_e;
      hu.HU_StallE = mem_hold;
      hu.HU_StallM = mem_hold;
      hu.HU_FlushW = mem_hold;
      hu.HU_MemErr = memerr_q;
   end

   hu_sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (HU_CLK),
      .rst_i (HU_RST),
      .inc_i (stall_f),
      .cnt_o (hu.HU_StallCnt)
   );

   hu_sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (HU_CLK),
      .rst_i (HU_RST),
      .inc_i (flush_e),
      .cnt_o (hu.HU_FlushCnt)
   );
endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load-use and branch stalls,
// memory wait FSM, timeout, mid-wait reset and counter saturation.
module tb_hazard_unit;
   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 15;

   logic HU_CLK = 1'b0;
   logic HU_RST = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;
   int   exp_stall = 0;
   int   exp_flush = 0;

   hazard_unit_if #(.CNT_W(CNT_W)) hu_if ();

   hazard_unit #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .HU_CLK (HU_CLK),
      .HU_RST (HU_RST),
      .hu     (hu_if.slave)
   );

   always #5 HU_CLK = ~HU_CLK;

   task automatic idle();
      hu_if.HU_RsD = 5'd0; hu_if.HU_RtD = 5'd0; hu_if.HU_RsE = 5'd0; hu_if.HU_RtE = 5'd0;
      hu_if.HU_WriteRegE = 5'd0; hu_if.HU_WriteRegM = 5'd0; hu_if.HU_WriteRegW = 5'd0;
      hu_if.HU_RegWriteE = 1'b0; hu_if.HU_RegWriteM = 1'b0; hu_if.HU_RegWriteW = 1'b0;
      hu_if.HU_MemToRegE = 1'b0; hu_if.HU_MemToRegM = 1'b0; hu_if.HU_MemWriteM = 1'b0;
      hu_if.HU_BranchD = 1'b0; hu_if.HU_MemReadyM = 1'b1;
   endtask

   // Advance one clock and settle just after the edge.
   task automatic step();
      @(posedge HU_CLK);
      #1;
   endtask

   task automatic test_reset();
      idle();
      HU_RST = 1'b1;
      #1;
      n_total++; if (hu_if.HU_StallF !== 1'b0) $display("FAIL rst_stallf got=%0b exp=0", hu_if.HU_StallF); else n_pass++;
      n_total++; if (hu_if.HU_FlushE !== 1'b0) $display("FAIL rst_flushe got=%0b exp=0", hu_if.HU_FlushE); else n_pass++;
      n_total++; if (hu_if.HU_MemErr !== 1'b0) $display("FAIL rst_memerr got=%0b exp=0", hu_if.HU_MemErr); else n_pass++;
      n_total++; if (hu_if.HU_StallCnt !== 16'd0) $display("FAIL rst_stallcnt got=%0d exp=0", hu_if.HU_StallCnt); else n_pass++;
      n_total++; if (hu_if.HU_FlushCnt !== 16'd0) $display("FAIL rst_flushcnt got=%0d exp=0", hu_if.HU_FlushCnt); else n_pass++;
      n_total++; if (hu_if.HU_ForwardAE !== 2'b00) $display("FAIL rst_fwdae got=%b exp=00", hu_if.HU_ForwardAE); else n_pass++;
      step();
      step();
      HU_RST = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
      step();
   endtask

   task automatic test_forward();
      idle();
      hu_if.HU_RsE = 5'd8; hu_if.HU_RtE = 5'd8;
      hu_if.HU_WriteRegM = 5'd8; hu_if.HU_RegWriteM = 1'b1;
      #1;
      n_total++; if (hu_if.HU_ForwardAE !== 2'b10) $display("FAIL fwd_ae_mem got=%b exp=10", hu_if.HU_ForwardAE); else n_pass++;
      n_total++; if (hu_if.HU_ForwardBE !== 2'b10) $display("FAIL fwd_be_mem got=%b exp=10", hu_if.HU_ForwardBE); else n_pass++;
      n_total++; if (hu_if.HU_StallF !== 1'b0) $display("FAIL fwd_nostall got=%0b exp=0", hu_if.HU_StallF); else n_pass++;
      // one cycle later the producer sits in writeback
      hu_if.HU_WriteRegM = 5'd0; hu_if.HU_RegWriteM = 1'b0;
      hu_if.HU_WriteRegW = 5'd8; hu_if.HU_RegWriteW = 1'b1;
      #1;
      n_total++; if (hu_if.HU_ForwardAE !== 2'b01) $display("FAIL fwd_ae_wb got=%b exp=01", hu_if.HU_ForwardAE); else n_pass++;
      // both M and W match: M wins
      hu_if.HU_WriteRegM = 5'd8; hu_if.HU_RegWriteM = 1'b1;
      #1;
      n_total++; if (hu_if.HU_ForwardAE !== 2'b10) $display("FAIL fwd_ae_prio got=%b exp=10", hu_if.HU_ForwardAE); else n_pass++;
      // M matches but does not write: fall back to W
      hu_if.HU_RegWriteM = 1'b0;
      #1;
      n_total++; if (hu_if.HU_ForwardBE !== 2'b01) $display("FAIL fwd_be_nowrm got=%b exp=01", hu_if.HU_ForwardBE); else n_pass++;
      // register $0 is never forwarded
      hu_if.HU_RsE = 5'd0; hu_if.HU_WriteRegM = 5'd0; hu_if.HU_RegWriteM = 1'b1;
      hu_if.HU_WriteRegW = 5'd0;
      #1;
      n_total++; if (hu_if.HU_ForwardAE !== 2'b00) $display("FAIL fwd_ae_r0 got=%b exp=00", hu_if.HU_ForwardAE); else n_pass++;
      step();
   endtask

   task automatic test_lwstall();
      idle();
      hu_if.HU_MemToRegE = 1'b1; hu_if.HU_RtE = 5'd9; hu_if.HU_RsD = 5'd9;
      #1;
      n_total++; if (hu_if.HU_StallF !== 1'b1) $display("FAIL lw_stallf got=%0b exp=1", hu_if.HU_StallF); else n_pass++;
      n_total++; if (hu_if.HU_StallD !== 1'b1) $display("FAIL lw_stalld got=%0b exp=1", hu_if.HU_StallD); else n_pass++;
      n_total++; if (hu_if.HU_FlushE !== 1'b1) $display("FAIL lw_flushe got=%0b exp=1", hu_if.HU_FlushE); else n_pass++;
      n_total++; if (hu_if.HU_StallE !== 1'b0) $display("FAIL lw_stalle got=%0b exp=0", hu_if.HU_StallE); else n_pass++;
      step();
      exp_stall++; exp_flush++;
      idle();
      #1;
      n_total++; if (hu_if.HU_StallF !== 1'b0) $display("FAIL lw_release got=%0b exp=0", hu_if.HU_StallF); else n_pass++;
      n_total++; if (hu_if.HU_StallCnt !== 16'(exp_stall)) $display("FAIL lw_stallcnt got=%0d exp=%0d", hu_if.HU_StallCnt, exp_stall); else n_pass++;
      n_total++; if (hu_if.HU_FlushCnt !== 16'(exp_flush)) $display("FAIL lw_flushcnt got=%0d exp=%0d", hu_if.HU_FlushCnt, exp_flush); else n_pass++;
      // match through rt of the decode instruction
      hu_if.HU_MemToRegE = 1'b1; hu_if.HU_RtE = 5'd12; hu_if.HU_RtD = 5'd12;
      #1;
      n_total++; if (hu_if.HU_FlushE !== 1'b1) $display("FAIL lw_rtd got=%0b exp=1", hu_if.HU_FlushE); else n_pass++;
      step();
      exp_stall++; exp_flush++;
   endtask

   task automatic test_brstall();
      idle();
      hu_if.HU_BranchD = 1'b1; hu_if.HU_RsD = 5'd10;
      hu_if.HU_RegWriteE = 1'b1; hu_if.HU_WriteRegE = 5'd10;
      #1;
      n_total++; if (hu_if.HU_StallF !== 1'b1) $display("FAIL br_stallf got=%0b exp=1", hu_if.HU_StallF); else n_pass++;
      n_total++; if (hu_if.HU_FlushE !== 1'b1) $display("FAIL br_flushe got=%0b exp=1", hu_if.HU_FlushE); else n_pass++;
      step();
      exp_stall++; exp_flush++;
      hu_if.HU_RegWriteE = 1'b0; hu_if.HU_WriteRegE = 5'd0;
      hu_if.HU_WriteRegM = 5'd10; hu_if.HU_RegWriteM = 1'b1; hu_if.HU_RtD = 5'd10;
      #1;
      n_total++; if (hu_if.HU_ForwardAD !== 1'b1) $display("FAIL br_fwdad got=%0b exp=1", hu_if.HU_ForwardAD); else n_pass++;
      n_total++; if (hu_if.HU_ForwardBD !== 1'b1) $display("FAIL br_fwdbd got=%0b exp=1", hu_if.HU_ForwardBD); else n_pass++;
      n_total++; if (hu_if.HU_StallF !== 1'b0) $display("FAIL br_nostall got=%0b exp=0", hu_if.HU_StallF); else n_pass++;
      // a load in M feeding the branch does stall
      hu_if.HU_MemToRegM = 1'b1; hu_if.HU_MemReadyM = 1'b1;
      #1;
      n_total++; if (hu_if.HU_StallD !== 1'b1) $display("FAIL br_loadm got=%0b exp=1", hu_if.HU_StallD); else n_pass++;
      step();
      exp_stall++; exp_flush++;
      idle();
      #1;
      n_total++; if (hu_if.HU_StallCnt !== 16'(exp_stall)) $display("FAIL br_stallcnt got=%0d exp=%0d", hu_if.HU_StallCnt, exp_stall); else n_pass++;
   endtask

   task automatic test_memwait();
      idle();
      hu_if.HU_MemToRegM = 1'b1; hu_if.HU_MemReadyM = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         if (c == 2) begin
            // a load-use hazard during the wait must not flush E
            hu_if.HU_MemToRegE = 1'b1; hu_if.HU_RtE = 5'd9; hu_if.HU_RsD = 5'd9;
         end
         #1;
         n_total++; if ({hu_if.HU_StallF, hu_if.HU_StallD, hu_if.HU_StallE, hu_if.HU_StallM, hu_if.HU_FlushW} !== 5'b11111)
            $display("FAIL mw_hold c=%0d got=%b exp=11111", c,
                     {hu_if.HU_StallF, hu_if.HU_StallD, hu_if.HU_StallE, hu_if.HU_StallM, hu_if.HU_FlushW});
         else n_pass++;
         n_total++; if (hu_if.HU_FlushE !== 1'b0) $display("FAIL mw_flushe c=%0d got=%0b exp=0", c, hu_if.HU_FlushE); else n_pass++;
         step();
         exp_stall++;
      end
      hu_if.HU_MemToRegE = 1'b0; hu_if.HU_RtE = 5'd0; hu_if.HU_RsD = 5'd0;
      hu_if.HU_MemReadyM = 1'b1;
      #1;
      n_total++; if ({hu_if.HU_StallF, hu_if.HU_StallM, hu_if.HU_FlushW} !== 3'b000)
         $display("FAIL mw_ready got=%b exp=000", {hu_if.HU_StallF, hu_if.HU_StallM, hu_if.HU_FlushW});
      else n_pass++;
      step();
      idle();
      // back in RUN: a load-use hazard flushes E again
      hu_if.HU_MemToRegE = 1'b1; hu_if.HU_RtE = 5'd3; hu_if.HU_RsD = 5'd3;
      #1;
      n_total++; if (hu_if.HU_FlushE !== 1'b1) $display("FAIL mw_run got=%0b exp=1", hu_if.HU_FlushE); else n_pass++;
      n_total++; if (hu_if.HU_MemErr !== 1'b0) $display("FAIL mw_memerr got=%0b exp=0", hu_if.HU_MemErr); else n_pass++;
      n_total++; if (hu_if.HU_StallCnt !== 16'(exp_stall)) $display("FAIL mw_stallcnt got=%0d exp=%0d", hu_if.HU_StallCnt, exp_stall); else n_pass++;
      n_total++; if (hu_if.HU_FlushCnt !== 16'(exp_flush)) $display("FAIL mw_flushcnt got=%0d exp=%0d", hu_if.HU_FlushCnt, exp_flush); else n_pass++;
      step();
      exp_stall++; exp_flush++;
      idle();
   endtask

   task automatic test_timeout();
      idle();
      hu_if.HU_MemToRegM = 1'b1; hu_if.HU_MemReadyM = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         #1;
         n_total++; if (hu_if.HU_StallM !== 1'b1) $display("FAIL to_stallm k=%0d got=%0b exp=1", k, hu_if.HU_StallM); else n_pass++;
         step();
         n_total++; if (hu_if.HU_MemErr !== (k >= TIMEOUT))
            $display("FAIL to_memerr k=%0d got=%0b exp=%0b", k, hu_if.HU_MemErr, (k >= TIMEOUT));
         else n_pass++;
      end
      // reset mid-wait with memory still not ready
      HU_RST = 1'b1;
      #1;
      n_total++; if ({hu_if.HU_StallF, hu_if.HU_StallE, hu_if.HU_StallM, hu_if.HU_FlushW} !== 4'b0000)
         $display("FAIL to_rst_stalls got=%b exp=0000",
                  {hu_if.HU_StallF, hu_if.HU_StallE, hu_if.HU_StallM, hu_if.HU_FlushW});
      else n_pass++;
      n_total++; if (hu_if.HU_MemErr !== 1'b0) $display("FAIL to_rst_memerr got=%0b exp=0", hu_if.HU_MemErr); else n_pass++;
      n_total++; if (hu_if.HU_StallCnt !== 16'd0) $display("FAIL to_rst_stallcnt got=%0d exp=0", hu_if.HU_StallCnt); else n_pass++;
      n_total++; if (hu_if.HU_FlushCnt !== 16'd0) $display("FAIL to_rst_flushcnt got=%0d exp=0", hu_if.HU_FlushCnt); else n_pass++;
      idle();
      step();
      HU_RST = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
      #1;
      n_total++; if (hu_if.HU_StallF !== 1'b0) $display("FAIL to_post_rst got=%0b exp=0", hu_if.HU_StallF); else n_pass++;
      step();
   endtask

   task automatic test_saturation();
      idle();
      hu_if.HU_MemToRegE = 1'b1; hu_if.HU_RtE = 5'd9; hu_if.HU_RsD = 5'd9;
      for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
         step();
         if (exp_stall < (1 << CNT_W) - 1) exp_stall++;
         if (exp_flush < (1 << CNT_W) - 1) exp_flush++;
      end
      idle();
      #1;
      n_total++; if (hu_if.HU_StallCnt !== 16'(exp_stall)) $display("FAIL sat_stallcnt got=%0d exp=%0d", hu_if.HU_StallCnt, exp_stall); else n_pass++;
      n_total++; if (hu_if.HU_FlushCnt !== 16'(exp_flush)) $display("FAIL sat_flushcnt got=%0d exp=%0d", hu_if.HU_FlushCnt, exp_flush); else n_pass++;
      n_total++; if (hu_if.HU_StallCnt !== 16'hFFFF) $display("FAIL sat_allones got=%h exp=ffff", hu_if.HU_StallCnt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_forward();
      test_lwstall();
      test_brstall();
      test_memwait();
      test_timeout();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
